// File: rtl/mdu_ctrl.sv
// mdu_ctrl: fixed-latency multiply/divide unit with HI/LO registers and hazard stall request.
// The divider is built only when MDU_DIV_EN is defined; otherwise ops 3/4 behave as no-ops.
module mdu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hl_sel,
    input  logic        md_use_D,
    output logic [31:0] HL_out,
    output logic        busy,
    output logic        stall_req
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 4;
    localparam logic [CW-1:0] MULT_CNT = CW'(4);
`ifdef MDU_DIV_EN
    localparam logic [CW-1:0] DIV_CNT  = CW'(9);

    typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1} state_e;
`endif

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic              sgn_q, sgn_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic              is_mul_op, is_div_op;
    logic signed [2*XLEN-1:0] a_ext, b_ext, prod;

    assign is_mul_op = (op == 3'd1) || (op == 3'd2);
`ifdef MDU_DIV_EN
    assign is_div_op = (op == 3'd3) || (op == 3'd4);
`else
    assign is_div_op = 1'b0;
`endif

    // Extending both operands to 64 bits makes one multiplier serve signed and unsigned modes.
    always_comb begin
        a_ext = {{XLEN{sgn_q & a_q[XLEN-1]}}, a_q};
        b_ext = {{XLEN{sgn_q & b_q[XLEN-1]}}, b_q};
        prod  = a_ext * b_ext;
    end

`ifdef MDU_DIV_EN
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    // Divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows dividend.
    always_comb begin
        a_neg = sgn_q & a_q[XLEN-1];
        b_neg = sgn_q & b_q[XLEN-1];
        a_mag = a_neg ? -a_q : a_q;
        b_mag = b_neg ? -b_q : b_q;
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem   = a_neg ? -r_mag : r_mag;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (is_mul_op) begin
                    a_d     = A;
                    b_d     = B;
                    sgn_d   = (op == 3'd1);
                    cnt_d   = MULT_CNT;
                    state_d = MULT;
                end
`ifdef MDU_DIV_EN
                else if (is_div_op) begin
                    a_d     = A;
                    b_d     = B;
                    sgn_d   = (op == 3'd3);
                    cnt_d   = DIV_CNT;
                    state_d = DIV;
                end
`endif
                else if (op == 3'd5) begin
                    hi_d = A;
                end else if (op == 3'd6) begin
                    lo_d = A;
                end
            end
            MULT: begin
                if (cnt_q == CW'(0)) begin
                    hi_d    = prod[2*XLEN-1:XLEN];
                    lo_d    = prod[XLEN-1:0];
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef MDU_DIV_EN
            DIV: begin
                if (cnt_q == CW'(0)) begin
                    if (b_q != XLEN'(0)) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign stall_req = md_use_D & (busy | is_mul_op | is_div_op);
    assign HL_out    = hl_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and randomized checks of mdu_ctrl against a cycle-count reference model.
`timescale 1ns/1ps
module tb_mdu_ctrl;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        hl_sel = 1'b0;
    logic        md_use_D = 1'b0;
    logic [31:0] HL_out;
    logic        busy;
    logic        stall_req;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .A        (A),
        .B        (B),
        .hl_sel   (hl_sel),
        .md_use_D (md_use_D),
        .HL_out   (HL_out),
        .busy     (busy),
        .stall_req(stall_req)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining cycles of the in-flight op, results from plain 64-bit arithmetic.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_a = 32'd0, m_b = 32'd0;
    int          m_left = 0;
    bit          m_div = 1'b0, m_sgn = 1'b0;

    task automatic finish_op();
        longint sa, sb, p, q, r;
        sa = m_sgn ? longint'($signed(m_a)) : longint'(m_a);
        sb = m_sgn ? longint'($signed(m_b)) : longint'(m_b);
        if (!m_div) begin
            p = sa * sb;
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (m_b != 32'd0) begin
            q = sa / sb;
            r = sa % sb;
            m_lo = q[31:0];
            m_hi = r[31:0];
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = 32'd0; m_lo = 32'd0; m_a = 32'd0; m_b = 32'd0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) finish_op();
        end else begin
            case (op)
                3'd1, 3'd2: begin
                    m_a = A; m_b = B; m_sgn = (op == 3'd1); m_div = 1'b0; m_left = 5;
                end
                3'd3, 3'd4: if (DIV_EN) begin
                    m_a = A; m_b = B; m_sgn = (op == 3'd3); m_div = 1'b1; m_left = 10;
                end
                3'd5: m_hi = A;
                3'd6: m_lo = A;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [31:0] exp_hl;
        logic        op_md, exp_stall;
        exp_hl    = hl_sel ? m_hi : m_lo;
        op_md     = (op == 3'd1) || (op == 3'd2) || (DIV_EN && ((op == 3'd3) || (op == 3'd4)));
        exp_stall = md_use_D && ((m_left > 0) || op_md);
        chk("hl_out", HL_out, exp_hl);
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("stall_req", 32'(stall_req), 32'(exp_stall));
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic read_hl(input string name, input logic sel, input logic [31:0] exp);
        hl_sel = sel;
        #1;
        chk(name, HL_out, exp);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #2;
        read_hl("rst_hi", 1'b1, 32'd0);
        read_hl("rst_lo", 1'b0, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        nxt();

        // signed mult: busy for exactly five cycles, old value visible until completion
        op = 3'd1; A = 32'hFFFF_FFFF; B = 32'd2;
        nxt();
        op = 3'd0;
        for (int c = 0; c < 5; c++) begin
            #1 chk("mult_busy", 32'(busy), 32'd1);
            if (c == 4) read_hl("mult_no_bypass", 1'b1, 32'd0);
            nxt();
        end
        chk("mult_done_busy", 32'(busy), 32'd0);
        read_hl("mult_hi", 1'b1, 32'hFFFF_FFFF);
        read_hl("mult_lo", 1'b0, 32'hFFFF_FFFE);
        chk("model_mult_hi", m_hi, 32'hFFFF_FFFF);
        nxt();

        op = 3'd2; A = 32'hFFFF_FFFF; B = 32'd2;
        nxt();
        op = 3'd0;
        repeat (5) nxt();
        read_hl("multu_hi", 1'b1, 32'h0000_0001);
        read_hl("multu_lo", 1'b0, 32'hFFFF_FFFE);
        chk("model_multu_hi", m_hi, 32'h0000_0001);

        // mthi/mtlo visible the cycle after the write
        op = 3'd5; A = 32'h1234_5678;
        nxt();
        op = 3'd6; A = 32'hCAFE_F00D;
        read_hl("mthi", 1'b1, 32'h1234_5678);
        nxt();
        op = 3'd0;
        read_hl("mtlo", 1'b0, 32'hCAFE_F00D);
        chk("mt_no_busy", 32'(busy), 32'd0);
        nxt();

        if (DIV_EN) begin
            // divu by zero leaves HI/LO untouched
            op = 3'd4; A = 32'd55; B = 32'd0;
            nxt();
            op = 3'd0;
            repeat (10) nxt();
            chk("div0_busy", 32'(busy), 32'd0);
            read_hl("div0_hi", 1'b1, 32'h1234_5678);
            read_hl("div0_lo", 1'b0, 32'hCAFE_F00D);

            // signed div with an ignored mult in flight and stall held
            md_use_D = 1'b1;
            op = 3'd3; A = 32'hFFFF_FFF9; B = 32'd2;
            #1 chk("div_issue_stall", 32'(stall_req), 32'd1);
            nxt();
            for (int c = 1; c <= 10; c++) begin
                op = (c == 3) ? 3'd1 : 3'd0;
                A = 32'd3; B = 32'd3;
                #1;
                chk("div_busy", 32'(busy), 32'd1);
                chk("div_stall", 32'(stall_req), 32'd1);
                nxt();
            end
            op = 3'd0;
            md_use_D = 1'b0;
            chk("div_done_busy", 32'(busy), 32'd0);
            read_hl("div_lo", 1'b0, 32'hFFFF_FFFD);
            read_hl("div_hi", 1'b1, 32'hFFFF_FFFF);
            chk("model_div_lo", m_lo, 32'hFFFF_FFFD);
            nxt();

            op = 3'd3; A = 32'h8000_0000; B = 32'hFFFF_FFFF;
            nxt();
            op = 3'd0;
            repeat (10) nxt();
            read_hl("ovf_lo", 1'b0, 32'h8000_0000);
            read_hl("ovf_hi", 1'b1, 32'd0);
            op = 3'd5; A = 32'h1234_5678;
            nxt();
            op = 3'd0;
        end else begin
            // div is a no-op without the divider
            md_use_D = 1'b1;
            op = 3'd3; A = 32'd100; B = 32'd7;
            #1 chk("nodiv_stall", 32'(stall_req), 32'd0);
            nxt();
            op = 3'd0;
            chk("nodiv_busy", 32'(busy), 32'd0);
            md_use_D = 1'b0;
            repeat (10) nxt();
            read_hl("nodiv_hi", 1'b1, 32'h1234_5678);
            read_hl("nodiv_lo", 1'b0, 32'hCAFE_F00D);
        end
        nxt();

        // reset mid-mult: immediate clear, no late write
        op = 3'd1; A = 32'd5; B = 32'd6;
        nxt();
        op = 3'd0;
        nxt();
        #1 reset = 1'b0;
        #1 chk("rst_mid_busy", 32'(busy), 32'd0);
        read_hl("rst_mid_hi", 1'b1, 32'd0);
        read_hl("rst_mid_lo", 1'b0, 32'd0);
        nxt();
        reset = 1'b1;
        repeat (8) nxt();
        read_hl("rst_nowrite_hi", 1'b1, 32'd0);
        read_hl("rst_nowrite_lo", 1'b0, 32'd0);
        chk("rst_nowrite_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            op       = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            A        = rnd_operand();
            B        = rnd_operand();
            hl_sel   = 1'($urandom);
            md_use_D = 1'($urandom);
            reset    = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            nxt();
        end
        reset = 1'b1;
        op = 3'd0;
        repeat (12) nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port op  input  3  E-stage command, valid only while E advances: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-004 SHALL have port A  input  32  rs operand (forwarded).
REQ-005 SHALL have port B  input  32  rt operand (forwarded).
REQ-006 SHALL have port hl_sel  input  1  read select: 0 LO, 1 HI.
REQ-007 SHALL have port md_use_D  input  1  D-stage instruction is a mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 SHALL have port HL_out  output  32  combinational read of HI or LO per hl_sel.
REQ-009 SHALL have port busy  output  1  high while an operation is in flight.
REQ-010 SHALL have port stall_req  output  1  stall request to the hazard unit.

Function
REQ-011 SHALL implement an FSM with states IDLE, MULT and DIV, plus a 4-bit down-counter cnt.
REQ-012 In IDLE, op 1/2 SHALL latch A and B, load cnt=4 and enter MULT; op 3/4 SHALL latch A and B, load cnt=9 and enter DIV; the latched sign mode SHALL be signed for ops 1/3 and unsigned for ops 2/4.
REQ-013 In MULT/DIV, cnt SHALL decrement every cycle; on the edge where cnt==0, HI/LO SHALL be written and the FSM SHALL return to IDLE.
REQ-014 Latency SHALL be 5 cycles for mult and 10 cycles for div, counted from the issue edge to the HI/LO write edge inclusive.
REQ-015 busy SHALL be high in MULT and DIV and low in IDLE.
REQ-016 stall_req SHALL equal md_use_D AND (busy OR op in {1,2,3,4}).
REQ-017 mult/multu SHALL write the 64-bit product of the latched operands: upper half to HI, lower half to LO; signed or unsigned per the latched mode.
REQ-018 div/divu SHALL write the quotient to LO and the remainder to HI; the signed quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-019 A divisor of 0 SHALL leave HI and LO unchanged at completion.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL produce LO=0x80000000 and HI=0.
REQ-021 op 5/6 in IDLE SHALL write A to HI/LO at the next edge, with no busy cycle.
REQ-022 Any op other than 0 arriving while busy SHALL be ignored; the in-flight operation SHALL be unaffected.
REQ-023 HL_out SHALL show the old value until the completion edge (no bypass of in-flight results).
REQ-024 HL_out SHALL reflect an mthi/mtlo write from the cycle after that write.

Reset
REQ-025 reset low SHALL immediately force HI=0, LO=0, cnt=0, latched operands=0 and state IDLE, independent of clk.
REQ-026 While reset is low, busy=0; stall_req SHALL then reduce to md_use_D AND (op in {1,2,3,4}).
REQ-027 Reset asserted mid-operation SHALL abort the operation; no HI/LO write SHALL occur afterward.

Configuration
REQ-028 With macro MDU_DIV_EN defined, div/divu SHALL behave as specified above.
REQ-029 Without MDU_DIV_EN, ops 3/4 SHALL be treated as op 0: DIV state and divider logic absent, busy never set by them, and stall_req excluding ops 3/4.

Verification
REQ-030 mult with A=0xFFFFFFFF, B=2 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-031 multu with A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
REQ-032 div with A=-7, B=2 (MDU_DIV_EN) -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; mult issued at cycle 3 is ignored; stall_req high throughout while md_use_D=1.
REQ-033 divu with B=0 after mthi 0x12345678 -> HI stays 0x12345678 and LO is unchanged after 10 cycles.
REQ-034 mult issued, then reset pulsed low at cycle 2 -> HI=LO=0 and busy=0 immediately, with no later write.
REQ-035 Build without MDU_DIV_EN, issue div -> busy stays 0, HI/LO unchanged, stall_req=0.
